point_on_curve_check: RTL



---
 rtl/point_on_curve_check.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/point_on_curve_check.sv
// Validates that an affine point lies on y^2 = x^3 + a*x + b (mod p).
// Uses one shared bit-serial interleaved modular multiplier; fixed 4n+2 cycle busy period.
//
// state   | meaning
// IDLE    | waiting for start; operands latched on acceptance
// MUL_YY  | yy = y*y
// MUL_XX  | t  = x*x
// MUL_XXX | t  = t*x
// MUL_AX  | u  = a*x
// SUM     | r = t + u + (b mod p); verdict registered
// DONE    | done pulse, verdict valid
module point_on_curve_check #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         inf,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] p,
  output logic         ready,
  output logic         done,
  output logic         on_curve
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_YY  = 3'd1,
    MUL_XX  = 3'd2,
    MUL_XXX = 3'd3,
    MUL_AX  = 3'd4,
    SUM     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [n-1:0]  op_x, op_y, op_a, op_b, op_p;
  logic          op_inf;
  logic [n:0]    acc, yy, t, u;

  logic          mul_active;
  logic          mul_last;
  logic [n:0]    pe;
  logic [n:0]    mcand;
  logic [n-1:0]  mplier;
  logic          mbit;
  logic [n:0]    dbl, dbl_r, add, add_r, acc_nxt;
  logic [n:0]    s1, s1_r, b_r, s2, s2_r;
  logic          range_err;
  logic          verdict;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL_YY;
      MUL_YY:  if (cnt == '0) state_nxt = MUL_XX;
      MUL_XX:  if (cnt == '0) state_nxt = MUL_XXX;
      MUL_XXX: if (cnt == '0) state_nxt = MUL_AX;
      MUL_AX:  if (cnt == '0) state_nxt = SUM;
      SUM:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- multiplier step
  assign mul_active = (state == MUL_YY) || (state == MUL_XX) ||
                      (state == MUL_XXX) || (state == MUL_AX);
  assign mul_last   = mul_active && (cnt == '0);
  assign pe         = {1'b0, op_p};

  always_comb begin
    mcand  = '0;
    mplier = '0;
    case (state)
      MUL_YY: begin
        mcand  = {1'b0, op_y};
        mplier = op_y;
      end
      MUL_XX: begin
        mcand  = {1'b0, op_x};
        mplier = op_x;
      end
      MUL_XXX: begin
        mcand  = t;
        mplier = op_x;
      end
      MUL_AX: begin
        mcand  = {1'b0, op_a};
        mplier = op_x;
      end
      default: ;
    endcase
  end

  assign mbit  = mplier[cnt];
  // acc < p < 2^n, so the doubling never loses a set bit for in-range operands
  assign dbl     = acc << 1;
  assign dbl_r   = (dbl >= pe) ? (dbl - pe) : dbl;
  assign add     = dbl_r + mcand;
  assign add_r   = (add >= pe) ? (add - pe) : add;
  assign acc_nxt = mbit ? add_r : dbl_r;

  // ---------------------------------------------------------------- final sum and verdict
  assign s1        = t + u;
  assign s1_r      = (s1 >= pe) ? (s1 - pe) : s1;
  assign b_r       = ({1'b0, op_b} >= pe) ? ({1'b0, op_b} - pe) : {1'b0, op_b};
  assign s2        = s1_r + b_r;
  assign s2_r      = (s2 >= pe) ? (s2 - pe) : s2;
  assign range_err = (op_x >= op_p) || (op_y >= op_p);
  assign verdict   = op_inf || (!range_err && (yy == s2_r));

  // ---------------------------------------------------------------- bit counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == IDLE && start) begin
      cnt <= CNT_LAST;
    end else if (mul_active) begin
      cnt <= (cnt == '0) ? CNT_LAST : (cnt - CW'(1));
    end
  end

  // ---------------------------------------------------------------- operands and accumulators
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_x     <= '0;
      op_y     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_p     <= '0;
      op_inf   <= 1'b0;
      acc      <= '0;
      yy       <= '0;
      t        <= '0;
      u        <= '0;
      on_curve <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_x     <= x;
            op_y     <= y;
            op_a     <= a;
            op_b     <= b;
            op_p     <= p;
            op_inf   <= inf;
            acc      <= '0;
            on_curve <= 1'b0;
          end
        end
        MUL_YY, MUL_XX, MUL_XXX, MUL_AX: begin
          if (mul_last) begin
            acc <= '0;
            case (state)
              MUL_YY:  yy <= acc_nxt;
              MUL_AX:  u  <= acc_nxt;
              default: t  <= acc_nxt;
            endcase
          end else begin
            acc <= acc_nxt;
          end
        end
        SUM: on_curve <= verdict;
        default: ;
      endcase
    end
  end

endmodule
